// File: rtl/lsu_bus_pkg.sv
// -----------------------------------------------------------------------------
// lsu_bus_pkg
// Shared types and default address map for the LSU bus arbiter and any other
// bus user that needs to classify an address.
//   arb_state_e : arbiter FSM states
//   region_e    : result of an address decode
//   LSU_*       : default address-map constants (DMEM base is 0)
// -----------------------------------------------------------------------------
package lsu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DMEM_ACC = 2'd1,
    IO_WAIT  = 2'd2,
    RESP     = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    REG_DMEM = 2'd0,
    REG_IO   = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  localparam logic [31:0] LSU_DMEM_TOP   = 32'h0000_07FF;
  localparam logic [31:0] LSU_IO_BASE    = 32'h1000_0000;
  localparam logic [31:0] LSU_IO_TOP     = 32'h1001_0FFF;
  localparam int unsigned LSU_IO_TIMEOUT = 255;

  // Master identifiers as stored in the owner / round-robin registers.
  localparam logic LSU_M0 = 1'b0;
  localparam logic LSU_M1 = 1'b1;

endpackage

// File: rtl/addr_region_decode.sv
// -----------------------------------------------------------------------------
// addr_region_decode
// Combinational byte-address classifier: DMEM (0..DMEM_TOP), IO
// (IO_BASE..IO_TOP) or unmapped.
// Ports:
//   i_addr   : byte address
//   o_region : REG_DMEM / REG_IO / REG_NONE
// -----------------------------------------------------------------------------
module addr_region_decode
  import lsu_bus_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] DMEM_TOP = ADDR_W'(LSU_DMEM_TOP),
  parameter logic [ADDR_W-1:0] IO_BASE  = ADDR_W'(LSU_IO_BASE),
  parameter logic [ADDR_W-1:0] IO_TOP   = ADDR_W'(LSU_IO_TOP)
) (
  input  logic [ADDR_W-1:0] i_addr,
  output region_e           o_region
);

  always_comb begin
    o_region = REG_NONE;
    if (i_addr <= DMEM_TOP) begin
      o_region = REG_DMEM;
    end else if ((i_addr >= IO_BASE) && (i_addr <= IO_TOP)) begin
      o_region = REG_IO;
    end
  end

endmodule

// File: rtl/lsu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// lsu_bus_arbiter
// Shares the data-memory port and the IO port between M0 (core LSU) and M1
// (debug/DMA). One transaction in flight: grant in IDLE, then DMEM_ACC (one
// dmem strobe), IO_WAIT (hold o_io_valid until i_io_ready) or straight to RESP
// for unmapped addresses; RESP returns a one-cycle rvalid to the owner.
// Ties are broken round-robin; after reset M0 wins the first tie.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   : IO_WAIT gives up after IO_TIMEOUT cycles and answers err=1
//   undefined : IO_WAIT waits for i_io_ready indefinitely
//
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_mX_req/addr/wren/wdata/bmask requester X access (held until o_mX_gnt)
//   o_mX_gnt                       request accepted this cycle (combinational)
//   o_mX_rvalid/rdata/err          one-cycle response to requester X
//   o_dmem_*, i_dmem_rdata         data-memory port (1-cycle read latency)
//   o_io_*, i_io_ready, i_io_rdata IO port with ready handshake
// -----------------------------------------------------------------------------
module lsu_bus_arbiter
  import lsu_bus_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] DMEM_TOP   = ADDR_W'(LSU_DMEM_TOP),
  parameter logic [ADDR_W-1:0] IO_BASE    = ADDR_W'(LSU_IO_BASE),
  parameter logic [ADDR_W-1:0] IO_TOP     = ADDR_W'(LSU_IO_TOP),
  parameter int unsigned       IO_TIMEOUT = LSU_IO_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_reset,

  input  logic              i_m0_req,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic              i_m0_wren,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic [3:0]        i_m0_bmask,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic              o_m0_err,

  input  logic              i_m1_req,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic              i_m1_wren,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic [3:0]        i_m1_bmask,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_m1_err,

  output logic              o_dmem_en,
  output logic              o_dmem_wren,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  output logic [3:0]        o_dmem_bmask,
  input  logic [DATA_W-1:0] i_dmem_rdata,

  output logic              o_io_valid,
  output logic              o_io_wren,
  output logic [ADDR_W-1:0] o_io_addr,
  output logic [DATA_W-1:0] o_io_wdata,
  output logic [3:0]        o_io_bmask,
  input  logic              i_io_ready,
  input  logic [DATA_W-1:0] i_io_rdata
);

  arb_state_e        r_state;
  logic              r_rr_last;
  logic              r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wren;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_bmask;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              r_from_dmem;

  logic              w_idle;
  logic              w_dmem_acc;
  logic              w_io_wait;
  logic              w_resp;
  logic              w_win_m1;
  logic              w_grant;
  logic [ADDR_W-1:0] w_win_addr;
  region_e           w_region;
  logic              w_tmo;
  logic [DATA_W-1:0] w_resp_rdata;

  assign w_idle     = (r_state == IDLE);
  assign w_dmem_acc = (r_state == DMEM_ACC);
  assign w_io_wait  = (r_state == IO_WAIT);
  assign w_resp     = (r_state == RESP);

  // M1 wins when it is the only requester, or on a tie when M0 was granted last.
  assign w_win_m1   = i_m1_req & (~i_m0_req | (r_rr_last == LSU_M0));
  // No grant while reset is asserted: the accepted request would be lost.
  assign w_grant    = w_idle & (i_m0_req | i_m1_req) & ~i_reset;
  assign o_m0_gnt   = w_grant & ~w_win_m1;
  assign o_m1_gnt   = w_grant & w_win_m1;
  assign w_win_addr = w_win_m1 ? i_m1_addr : i_m0_addr;

  addr_region_decode #(
    .ADDR_W   (ADDR_W),
    .DMEM_TOP (DMEM_TOP),
    .IO_BASE  (IO_BASE),
    .IO_TOP   (IO_TOP)
  ) u_decode (
    .i_addr   (w_win_addr),
    .o_region (w_region)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned       TMO_W    = (IO_TIMEOUT > 255) ? $clog2(IO_TIMEOUT + 1) : 8;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(IO_TIMEOUT - 1);

  logic [TMO_W-1:0] r_tmo_cnt;

  // Counts IO_WAIT cycles; zero in the first cycle of every IO_WAIT visit,
  // so o_io_valid stays up for exactly IO_TIMEOUT cycles before giving up.
  always_ff @(posedge i_clk) begin
    if (i_reset || !w_io_wait) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_tmo = w_io_wait & ~i_io_ready & (r_tmo_cnt == TMO_LAST);
`else
  assign w_tmo = 1'b0;
`endif

  // FSM and arbitration state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_rr_last <= LSU_M1;
      r_owner   <= LSU_M0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner   <= w_win_m1;
            r_rr_last <= w_win_m1;
            unique case (w_region)
              REG_DMEM: r_state <= DMEM_ACC;
              REG_IO:   r_state <= IO_WAIT;
              default:  r_state <= RESP;
            endcase
          end
        end
        DMEM_ACC: r_state <= RESP;
        IO_WAIT: begin
          if (i_io_ready || w_tmo) begin
            r_state <= RESP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Transaction fields and response payload
  always_ff @(posedge i_clk) begin
    if (w_grant) begin
      r_addr      <= w_win_addr;
      r_wren      <= w_win_m1 ? i_m1_wren  : i_m0_wren;
      r_wdata     <= w_win_m1 ? i_m1_wdata : i_m0_wdata;
      r_bmask     <= w_win_m1 ? i_m1_bmask : i_m0_bmask;
      r_rdata     <= '0;
      r_err       <= (w_region == REG_NONE);
      r_from_dmem <= (w_region == REG_DMEM);
    end else if (w_io_wait && i_io_ready) begin
      r_rdata     <= r_wren ? '0 : i_io_rdata;
    end else if (w_tmo) begin
      r_err       <= 1'b1;
    end
  end

  // DMEM load data arrives in the RESP cycle itself and is forwarded directly.
  assign w_resp_rdata = (r_from_dmem && !r_wren) ? i_dmem_rdata : r_rdata;

  assign o_m0_rvalid  = w_resp & (r_owner == LSU_M0);
  assign o_m1_rvalid  = w_resp & (r_owner == LSU_M1);
  assign o_m0_rdata   = o_m0_rvalid ? w_resp_rdata : '0;
  assign o_m1_rdata   = o_m1_rvalid ? w_resp_rdata : '0;
  assign o_m0_err     = o_m0_rvalid & r_err;
  assign o_m1_err     = o_m1_rvalid & r_err;

  // Port fields are zero outside their strobe so idle buses stay quiet.
  assign o_dmem_en    = w_dmem_acc;
  assign o_dmem_wren  = w_dmem_acc & r_wren;
  assign o_dmem_addr  = w_dmem_acc ? r_addr  : '0;
  assign o_dmem_wdata = w_dmem_acc ? r_wdata : '0;
  assign o_dmem_bmask = w_dmem_acc ? r_bmask : '0;

  assign o_io_valid   = w_io_wait;
  assign o_io_wren    = w_io_wait & r_wren;
  assign o_io_addr    = w_io_wait ? r_addr  : '0;
  assign o_io_wdata   = w_io_wait ? r_wdata : '0;
  assign o_io_bmask   = w_io_wait ? r_bmask : '0;

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lsu_bus_arbiter
// Directed scenarios with hand-computed expectations, followed by randomized
// traffic from both masters checked every cycle against a transaction-level
// model of the arbiter.
// -----------------------------------------------------------------------------
module tb_lsu_bus_arbiter;

  localparam int TMO    = 4;
  localparam int K_DMEM = 1;
  localparam int K_IO   = 2;
  localparam int K_NONE = 3;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_m0_req, i_m0_wren, i_m1_req, i_m1_wren;
  logic [31:0] i_m0_addr, i_m0_wdata, i_m1_addr, i_m1_wdata;
  logic [3:0]  i_m0_bmask, i_m1_bmask;
  logic        o_m0_gnt, o_m0_rvalid, o_m0_err, o_m1_gnt, o_m1_rvalid, o_m1_err;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic        o_dmem_en, o_dmem_wren;
  logic [31:0] o_dmem_addr, o_dmem_wdata, i_dmem_rdata;
  logic [3:0]  o_dmem_bmask;
  logic        o_io_valid, o_io_wren, i_io_ready;
  logic [31:0] o_io_addr, o_io_wdata, i_io_rdata;
  logic [3:0]  o_io_bmask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  lsu_bus_arbiter #(.IO_TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m0_req(i_m0_req), .i_m0_addr(i_m0_addr), .i_m0_wren(i_m0_wren),
    .i_m0_wdata(i_m0_wdata), .i_m0_bmask(i_m0_bmask), .o_m0_gnt(o_m0_gnt),
    .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata), .o_m0_err(o_m0_err),
    .i_m1_req(i_m1_req), .i_m1_addr(i_m1_addr), .i_m1_wren(i_m1_wren),
    .i_m1_wdata(i_m1_wdata), .i_m1_bmask(i_m1_bmask), .o_m1_gnt(o_m1_gnt),
    .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata), .o_m1_err(o_m1_err),
    .o_dmem_en(o_dmem_en), .o_dmem_wren(o_dmem_wren), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_bmask(o_dmem_bmask), .i_dmem_rdata(i_dmem_rdata),
    .o_io_valid(o_io_valid), .o_io_wren(o_io_wren), .o_io_addr(o_io_addr),
    .o_io_wdata(o_io_wdata), .o_io_bmask(o_io_bmask), .i_io_ready(i_io_ready),
    .i_io_rdata(i_io_rdata)
  );

  logic [209:0] all_outs;
  assign all_outs = {o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_m0_err, o_m1_err,
                     o_m0_rdata, o_m1_rdata,
                     o_dmem_en, o_dmem_wren, o_dmem_addr, o_dmem_wdata, o_dmem_bmask,
                     o_io_valid, o_io_wren, o_io_addr, o_io_wdata, o_io_bmask};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int region(input logic [31:0] a);
    if (a <= 32'h0000_07FF) return K_DMEM;
    if (a >= 32'h1000_0000 && a <= 32'h1001_0FFF) return K_IO;
    return K_NONE;
  endfunction

  function automatic int winner(input logic r0, input logic r1, input int last);
    if (r0 && r1) return (last == 0) ? 1 : 0;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  // ---------------- transaction-level reference model ----------------
  int          m_ok = 0, m_busy = 0, m_kind = 0, m_age = 0, m_owner = 0;
  int          m_last = 1, m_pend = 0, m_cnt = 0;
  logic [31:0] t_addr = 0, t_wdata = 0, m_rdata = 0;
  logic        t_wren = 0, m_err = 0;
  logic [3:0]  t_bmask = 0;

  always @(negedge i_clk) begin
    int          w;
    logic        e_g0, e_g1, e_rv0, e_rv1, e_er0, e_er1, rv, er;
    logic [31:0] e_d0, e_d1, rd;
    logic [69:0] e_dm, e_io;
    w = winner(i_m0_req, i_m1_req, m_last);
    e_g0 = 0; e_g1 = 0; e_rv0 = 0; e_rv1 = 0; e_er0 = 0; e_er1 = 0;
    e_d0 = 0; e_d1 = 0; rv = 0; er = 0; rd = 0; e_dm = 0; e_io = 0;
    if (m_busy == 0) begin
      if (!i_reset) begin
        e_g0 = (w == 0);
        e_g1 = (w == 1);
      end
    end else begin
      case (m_kind)
        K_DMEM: begin
          if (m_age == 1) e_dm = {1'b1, t_wren, t_addr, t_wdata, t_bmask};
          else begin rv = 1; rd = t_wren ? 32'h0 : i_dmem_rdata; end
        end
        K_IO: begin
          if (m_pend == 0) e_io = {1'b1, t_wren, t_addr, t_wdata, t_bmask};
          else begin rv = 1; rd = m_rdata; er = m_err; end
        end
        default: begin rv = 1; er = 1; end
      endcase
    end
    if (rv) begin
      if (m_owner == 0) begin e_rv0 = 1; e_er0 = er; e_d0 = rd; end
      else begin e_rv1 = 1; e_er1 = er; e_d1 = rd; end
    end
    if (m_ok != 0) begin
      chk("model gnt", 256'({o_m0_gnt, o_m1_gnt}), 256'({e_g0, e_g1}));
      chk("model m0 resp", 256'({o_m0_rvalid, o_m0_err, o_m0_rdata}), 256'({e_rv0, e_er0, e_d0}));
      chk("model m1 resp", 256'({o_m1_rvalid, o_m1_err, o_m1_rdata}), 256'({e_rv1, e_er1, e_d1}));
      chk("model dmem port", 256'({o_dmem_en, o_dmem_wren, o_dmem_addr, o_dmem_wdata, o_dmem_bmask}), 256'(e_dm));
      chk("model io port", 256'({o_io_valid, o_io_wren, o_io_addr, o_io_wdata, o_io_bmask}), 256'(e_io));
    end
    // advance to the next cycle
    if (i_reset) begin
      m_busy = 0; m_last = 1; m_ok = 1;
    end else if (m_busy == 0) begin
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_last = w; m_age = 1; m_pend = 0; m_cnt = 0;
        t_addr  = (w == 1) ? i_m1_addr  : i_m0_addr;
        t_wren  = (w == 1) ? i_m1_wren  : i_m0_wren;
        t_wdata = (w == 1) ? i_m1_wdata : i_m0_wdata;
        t_bmask = (w == 1) ? i_m1_bmask : i_m0_bmask;
        m_kind  = region(t_addr);
      end
    end else begin
      case (m_kind)
        K_DMEM: if (m_age == 1) m_age = 2; else m_busy = 0;
        K_IO: begin
          if (m_pend != 0) m_busy = 0;
          else if (i_io_ready) begin
            m_pend = 1; m_rdata = t_wren ? 32'h0 : i_io_rdata; m_err = 0;
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            m_cnt++;
            if (m_cnt == TMO) begin m_pend = 1; m_rdata = 0; m_err = 1; end
          end
`endif
        end
        default: m_busy = 0;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] gen_addr();
    case ($urandom_range(0, 9))
      0: return 32'h0000_07FF;
      1: return 32'h0000_0800;
      2: return 32'h0FFF_FFFF;
      3: return 32'h1000_0000;
      4: return 32'h1001_0FFF;
      5: return 32'h1001_1000;
      6, 7: return $urandom_range(0, 32'h7FF);
      8: return 32'h1000_0000 + $urandom_range(0, 32'h10FFF);
      default: return $urandom;
    endcase
  endfunction

  task automatic m0_txn(input logic [31:0] a, output int gc, output int lat, output logic e,
                        output logic [31:0] d, output int ndm, output int nio);
    gc = -1; lat = -1; e = 0; d = 0; ndm = 0; nio = 0;
    @(posedge i_clk); #1;
    i_m0_req = 1; i_m0_addr = a; i_m0_wren = 0; i_m0_wdata = 32'h0; i_m0_bmask = 4'hF;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_m0_gnt && gc < 0) gc = k;
      if (o_dmem_en) ndm++;
      if (o_io_valid) nio++;
      if (o_m0_rvalid) begin lat = k - gc; e = o_m0_err; d = o_m0_rdata; break; end
      @(posedge i_clk); #1;
      if (gc >= 0) i_m0_req = 0;
    end
    i_m0_req = 0;
  endtask

  logic [31:0] bnd_addr [6] = '{32'h0000_07FF, 32'h0000_0800, 32'h0FFF_FFFF,
                                32'h1000_0000, 32'h1001_0FFF, 32'h1001_1000};
  int          bnd_lat  [6] = '{2, 1, 1, 2, 2, 1};
  logic        bnd_err  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  int          bnd_dm   [6] = '{1, 0, 0, 0, 0, 0};
  int          bnd_io   [6] = '{0, 0, 0, 1, 1, 0};

  initial begin
    int gc, lat, ndm, nio, cnt, last_v, rv_k, gotg, unstable, ng, nrv0, nrv1;
    logic e, g0, g1;
    logic [31:0] d;
    logic [3:0] ghist;

    i_reset = 1; i_m0_req = 0; i_m1_req = 0; i_m0_wren = 0; i_m1_wren = 0;
    i_m0_addr = 0; i_m1_addr = 0; i_m0_wdata = 0; i_m1_wdata = 0;
    i_m0_bmask = 0; i_m1_bmask = 0; i_dmem_rdata = 0; i_io_ready = 1; i_io_rdata = 0;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 0;
    @(negedge i_clk);
    chk("reset outputs", 256'(all_outs), 256'(0));

    // M0 load from DMEM
    i_dmem_rdata = 32'hDEAD_BEEF;
    m0_txn(32'h0000_0010, gc, lat, e, d, ndm, nio);
    chk("dmem load timing", 256'({gc[7:0], lat[7:0], e, ndm[3:0], nio[3:0]}),
        256'({8'd0, 8'd2, 1'b0, 4'd1, 4'd0}));
    chk("dmem load rdata", 256'(d), 256'(32'hDEAD_BEEF));

    // address-map boundaries, IO ready immediately
    for (int i = 0; i < 6; i++) begin
      m0_txn(bnd_addr[i], gc, lat, e, d, ndm, nio);
      chk($sformatf("boundary %h", bnd_addr[i]),
          256'({gc[7:0], lat[7:0], e, ndm[3:0], nio[3:0]}),
          256'({8'd0, bnd_lat[i][7:0], bnd_err[i], bnd_dm[i][3:0], bnd_io[i][3:0]}));
    end

    // M1 IO store, ready held low for 5 valid cycles
    @(posedge i_clk); #1;
    i_io_ready = 0; i_io_rdata = 32'h1234_5678;
    i_m1_req = 1; i_m1_addr = 32'h1000_0004; i_m1_wren = 1; i_m1_wdata = 32'hCAFE_0001; i_m1_bmask = 4'h3;
    cnt = 0; last_v = -1; rv_k = -1; gotg = 0; unstable = 0; e = 0; d = 32'hFFFF_FFFF;
    for (int k = 0; k < 30; k++) begin
      @(negedge i_clk);
      if (o_m1_gnt) gotg = 1;
      if (o_io_valid) begin
        cnt++; last_v = k;
        if (o_io_addr !== 32'h1000_0004 || o_io_wren !== 1'b1 || o_io_wdata !== 32'hCAFE_0001 ||
            o_io_bmask !== 4'h3) unstable = 1;
      end
      if (o_m1_rvalid) begin rv_k = k; e = o_m1_err; d = o_m1_rdata; break; end
      @(posedge i_clk); #1;
      if (gotg != 0) i_m1_req = 0;
      if (cnt == 5) i_io_ready = 1;
    end
    i_m1_req = 0;
`ifdef ARB_TIMEOUT_EN
    chk("io valid cycles", 256'(cnt), 256'(TMO));
    chk("io timeout resp", 256'({unstable[0], e, d}), 256'({1'b0, 1'b1, 32'h0}));
`else
    chk("io valid cycles", 256'(cnt), 256'(6));
    chk("io store resp", 256'({unstable[0], e, d}), 256'({1'b0, 1'b0, 32'h0}));
`endif
    chk("io rvalid after last valid", 256'(rv_k - last_v), 256'(1));

    // reset while in IO_WAIT
    @(posedge i_clk); #1;
    i_io_ready = 0;
    i_m0_req = 1; i_m0_addr = 32'h1000_0008; i_m0_wren = 0; i_m0_bmask = 4'hF;
    @(negedge i_clk);
    chk("rst-io gnt", 256'(o_m0_gnt), 256'(1));
    @(posedge i_clk); #1 i_m0_req = 0;
    @(negedge i_clk);
    chk("rst-io valid", 256'(o_io_valid), 256'(1));
    @(posedge i_clk); #1 i_reset = 1;
    @(posedge i_clk); #1 i_reset = 0;
    @(negedge i_clk);
    chk("rst-io outputs", 256'(all_outs), 256'(0));
    i_io_ready = 1;

    // both masters request continuously: grants must alternate from M0
    @(posedge i_clk); #1;
    i_m0_req = 1; i_m0_addr = 32'h20; i_m1_req = 1; i_m1_addr = 32'h24; i_m1_wren = 0;
    ghist = 0; ng = 0; nrv0 = 0; nrv1 = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge i_clk);
      if (o_m0_gnt) begin ghist = {ghist[2:0], 1'b0}; ng++; end
      if (o_m1_gnt) begin ghist = {ghist[2:0], 1'b1}; ng++; end
      if (o_m0_rvalid) nrv0++;
      if (o_m1_rvalid) nrv1++;
      @(posedge i_clk); #1;
    end
    i_m0_req = 0; i_m1_req = 0;
    chk("alternating grants", 256'({ng[7:0], ghist}), 256'({8'd4, 4'b0101}));
    chk("one rvalid per grant", 256'({nrv0[7:0], nrv1[7:0]}), 256'({8'd2, 8'd2}));

    // randomized traffic checked by the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge i_clk);
      g0 = o_m0_gnt; g1 = o_m1_gnt;
      @(posedge i_clk); #1;
      i_reset      = ($urandom_range(0, 299) == 0);
      i_io_ready   = ($urandom_range(0, 2) == 0);
      i_io_rdata   = $urandom;
      i_dmem_rdata = $urandom;
      if (i_m0_req && g0) i_m0_req = 0;
      if (i_m0_req) begin
        if ($urandom_range(0, 31) == 0) i_m0_req = 0;
      end else if ($urandom_range(0, 9) < 4) begin
        i_m0_req = 1; i_m0_addr = gen_addr(); i_m0_wren = 1'($urandom_range(0, 1));
        i_m0_wdata = $urandom; i_m0_bmask = 4'($urandom_range(0, 15));
      end
      if (i_m1_req && g1) i_m1_req = 0;
      if (i_m1_req) begin
        if ($urandom_range(0, 31) == 0) i_m1_req = 0;
      end else if ($urandom_range(0, 9) < 4) begin
        i_m1_req = 1; i_m1_addr = gen_addr(); i_m1_wren = 1'($urandom_range(0, 1));
        i_m1_wdata = $urandom; i_m1_bmask = 4'($urandom_range(0, 15));
      end
    end
    @(posedge i_clk); #1;
    i_reset = 0; i_m0_req = 0; i_m1_req = 0; i_io_ready = 1;
    repeat (12) @(posedge i_clk);
    @(negedge i_clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_bus_arbiter.md
Name: lsu_bus_arbiter

Overview:
- Shares the single data-memory port and the single IO port between two requesters: M0 = core LSU, M1 = debug/DMA master.
- Picks a winner and decodes its address into DMEM, IO or unmapped space.
- Sequences one transaction at a time: 1-cycle DMEM read latency, variable-latency IO handshake.
- Sits between the requesters and the dmem/IO blocks; replaces direct LSU-to-dmem wiring.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- DMEM_TOP, 32'h0000_07FF, last DMEM byte address; DMEM base is 0
- IO_BASE, 32'h1000_0000, first IO address
- IO_TOP, 32'h1001_0FFF, last IO address
- IO_TIMEOUT, 255, IO wait cycles before error; used only with ARB_TIMEOUT_EN

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_m0_req / i_m1_req  in  1  request valid
- i_m0_addr / i_m1_addr  in  ADDR_W  byte address
- i_m0_wren / i_m1_wren  in  1  1 = store
- i_m0_wdata / i_m1_wdata  in  DATA_W  store data
- i_m0_bmask / i_m1_bmask  in  4  byte enables
- o_m0_gnt / o_m1_gnt  out  1  request accepted this cycle
- o_m0_rvalid / o_m1_rvalid  out  1  response pulse, 1 cycle
- o_m0_rdata / o_m1_rdata  out  DATA_W  load data, valid with rvalid
- o_m0_err / o_m1_err  out  1  unmapped or timeout, valid with rvalid
- o_dmem_en, o_dmem_wren  out  1  dmem access strobe and write enable
- o_dmem_addr  out  ADDR_W; o_dmem_wdata  out  DATA_W; o_dmem_bmask  out  4
- i_dmem_rdata  in  DATA_W  valid 1 cycle after o_dmem_en with wren=0
- o_io_valid, o_io_wren  out  1; o_io_addr  out  ADDR_W; o_io_wdata  out  DATA_W; o_io_bmask  out  4
- i_io_ready  in  1  IO accepts/completes the access
- i_io_rdata  in  DATA_W  valid when i_io_ready=1

Behaviour:
- Reset:
  - All outputs are 0. FSM goes to IDLE. Round-robin pointer rr_last = M1, so M0 wins the first tie.
  - A reset mid-transaction aborts it with no response. o_io_valid drops in the next cycle.
- Decode is on the latched address:
  - DMEM = addr <= DMEM_TOP.
  - IO = IO_BASE <= addr <= IO_TOP.
  - Everything else is unmapped.
- FSM states: IDLE, DMEM_ACC, IO_WAIT, RESP.
- IDLE:
  - If any request is present, the winner is chosen: a single requester wins; if both request, the master that was not last granted wins.
  - o_mX_gnt=1 for the winner in the same cycle (combinational). addr, wren, wdata, bmask and owner are latched. rr_last is updated.
  - Next state: DMEM_ACC if DMEM, IO_WAIT if IO, RESP with err=1 if unmapped.
- DMEM_ACC:
  - o_dmem_en=1 for exactly one cycle with the latched fields.
  - Next state is RESP. rdata is captured from i_dmem_rdata in the RESP cycle for loads; stores return rdata=0.
- IO_WAIT:
  - o_io_valid is held with stable fields until i_io_ready=1.
  - On ready: i_io_rdata is captured (0 for stores), then go to RESP.
- RESP:
  - The owner's o_mX_rvalid=1 for one cycle with rdata and err; the other master's outputs stay 0. Next state is IDLE.
- Grant is only possible in IDLE, so there is at most one transaction in flight.
- Latency from gnt to rvalid: DMEM = 2 cycles; unmapped = 1 cycle; IO = (cycles until ready) + 1.
- Request rules:
  - A requester holds req and its fields stable until gnt.
  - A req that drops before gnt is ignored without error.
- Simultaneous events: a new request arriving in the RESP cycle is not granted until the next IDLE cycle. Back-to-back throughput is therefore one transaction per 3 cycles for DMEM.
- Boundaries:
  - addr 0x0000_07FF is DMEM; 0x0000_0800 is unmapped.
  - 0x0FFF_FFFF is unmapped; 0x1000_0000 and 0x1001_0FFF are IO; 0x1001_1000 is unmapped.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - An 8-bit-minimum wait counter runs in IO_WAIT. It is cleared on entry to IO_WAIT.
  - When the count reaches IO_TIMEOUT without i_io_ready: o_io_valid is dropped, and the FSM goes to RESP with err=1, rdata=0.
- Not defined: IO_WAIT waits indefinitely; no counter logic is synthesized.

Decomposition:
- Package lsu_bus_pkg holds:
  - state enum arb_state_e (IDLE, DMEM_ACC, IO_WAIT, RESP);
  - region enum region_e (REG_DMEM, REG_IO, REG_NONE);
  - the default address constants.
- Sub-module addr_region_decode: combinational addr -> region_e, shared with other bus users.

Test Plan:
- M0 load 0x0000_0010 alone, dmem rdata 0xDEAD_BEEF -> gnt cycle 0, o_dmem_en cycle 1, o_m0_rvalid cycle 2 with rdata 0xDEAD_BEEF, err=0.
- M0 and M1 both request continuously from reset -> grants alternate M0, M1, M0, M1; each gets exactly one rvalid per grant.
- M1 store to 0x1000_0004 with i_io_ready held low 5 cycles -> o_io_valid stable for 6 cycles; o_m1_rvalid 1 cycle after ready; err=0.
- M0 load 0x0000_0800, then 0x1001_1000 -> each gives rvalid 1 cycle after gnt with err=1; no dmem or IO strobe.
- ARB_TIMEOUT_EN, IO_TIMEOUT=4, ready never asserted -> o_io_valid drops after 4 wait cycles; rvalid with err=1, rdata=0.
- i_reset asserted during IO_WAIT -> next cycle all outputs 0, FSM in IDLE; after release, M0 wins the first tie.
